// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, default table size
// and the saturating counter next-state function.
package bp_pkg;

   localparam logic [1:0] STRONG_TAKEN     = 2'b00;
   localparam logic [1:0] WEAK_TAKEN       = 2'b01;
   localparam logic [1:0] WEAK_NOT_TAKEN   = 2'b11;
   localparam logic [1:0] STRONG_NOT_TAKEN = 2'b10;

   localparam int BP_INDEX_W = 4;

   function automatic logic [1:0] bp_next_state(input logic [1:0] state, input logic taken);
      logic [1:0] nxt;
      nxt = STRONG_NOT_TAKEN;
      case (state)
         STRONG_NOT_TAKEN: nxt = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
         WEAK_NOT_TAKEN:   nxt = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
         WEAK_TAKEN:       nxt = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
         STRONG_TAKEN:     nxt = taken ? STRONG_TAKEN   : WEAK_TAKEN;
         default:          nxt = STRONG_NOT_TAKEN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup, execute-resolution, redirect and statistics signals of the predictor.
interface bp_if #(parameter int XLEN = 32);

   logic [XLEN-1:0] if_pc;
   logic            predict_taken;
   logic [XLEN-1:0] predict_target;
   logic            ex_valid;
   logic            ex_is_branch;
   logic [XLEN-1:0] ex_pc;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;

   modport master (
      output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target,
      input  predict_taken, predict_target, flush, redirect_pc,
             stat_branches, stat_mispredicts
   );

   modport slave (
      input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target,
      output predict_taken, predict_target, flush, redirect_pc,
             stat_branches, stat_mispredicts
   );

endinterface

// File: rtl/branch_predict_unit_counter_next.sv
// Combinational 2-bit saturating counter step plus taken decode of the current state.
module bp_counter_next
   import bp_pkg::*;
(
   input  logic [1:0] i_state,
   input  logic       i_taken,
   output logic [1:0] o_next,
   output logic       o_taken
);

   assign o_next  = bp_next_state(i_state, i_taken);
   // Taken states (00, 01) share a zero MSB.
   assign o_taken = ~i_state[1];

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit counter predictor with BTB, mispredict redirect and statistics.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int INDEX_W = BP_INDEX_W,
   parameter int XLEN    = 32
)(
   input  logic clk,
   input  logic rst,
   bp_if.slave  bus
);

   localparam int ENTRIES = 1 << INDEX_W;
   localparam int TAG_W   = XLEN - INDEX_W - 2;

   logic [ENTRIES-1:0] r_valid;
   logic [1:0]         r_ctr    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];

   logic               r_flush;
   logic [XLEN-1:0]    r_redirect_pc;
   logic [31:0]        r_stat_branches;
   logic [31:0]        r_stat_mispredicts;

   logic [INDEX_W-1:0] w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;

   logic [INDEX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0]   w_ex_tag;
   logic               w_ex_tag_eq;
   logic               w_ex_hit;
   logic               w_resolve;
   logic               w_alias;
   logic [XLEN-1:0]    w_actual;
   logic               w_mispredict;
   logic [1:0]         w_ctr_next;
   logic               w_unused_ctr_taken;

   // Fetch-side lookup sees the table as it stood before this cycle's update.
   assign w_if_idx = bus.if_pc[INDEX_W+1:2];
   assign w_if_tag = bus.if_pc[XLEN-1:INDEX_W+2];
   assign w_if_hit = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);

   assign bus.predict_taken  = w_if_hit & ~r_ctr[w_if_idx][1];
   assign bus.predict_target = w_if_hit ? r_target[w_if_idx] : bus.if_pc + XLEN'(4);

   assign w_ex_idx    = bus.ex_pc[INDEX_W+1:2];
   assign w_ex_tag    = bus.ex_pc[XLEN-1:INDEX_W+2];
   assign w_ex_tag_eq = r_tag[w_ex_idx] == w_ex_tag;
   assign w_ex_hit    = r_valid[w_ex_idx] & w_ex_tag_eq;

   assign w_resolve = bus.ex_valid & bus.ex_is_branch;
   // A non-branch predicted taken means the BTB aliased onto a different instruction.
   assign w_alias   = bus.ex_valid & ~bus.ex_is_branch & bus.ex_pred_taken;

   assign w_actual     = (w_resolve & bus.ex_taken) ? bus.ex_target : bus.ex_pc + XLEN'(4);
   assign w_mispredict = (w_resolve & ((bus.ex_pred_target != w_actual) |
                                       (bus.ex_pred_taken != bus.ex_taken))) | w_alias;

   bp_counter_next u_counter_next (
      .i_state (r_ctr[w_ex_idx]),
      .i_taken (bus.ex_taken),
      .o_next  (w_ctr_next),
      .o_taken (w_unused_ctr_taken)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= STRONG_NOT_TAKEN;
         r_flush            <= 1'b0;
         r_redirect_pc      <= '0;
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else begin
         if (w_resolve) begin
            if (w_ex_hit) begin
               r_ctr[w_ex_idx] <= w_ctr_next;
            end else if (bus.ex_taken) begin
               r_valid[w_ex_idx] <= 1'b1;
               r_ctr[w_ex_idx]   <= WEAK_TAKEN;
            end
         end else if (w_alias && w_ex_tag_eq) begin
            r_valid[w_ex_idx] <= 1'b0;
         end

         r_flush <= w_mispredict;
         if (w_mispredict) r_redirect_pc <= w_actual;

         if (w_resolve && (r_stat_branches != 32'hFFFF_FFFF))
            r_stat_branches <= r_stat_branches + 32'd1;
         if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
   end

   // Tag and target are only meaningful under a valid bit, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_resolve && bus.ex_taken) begin
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= bus.ex_target;
      end
   end

   assign bus.flush            = r_flush;
   assign bus.redirect_pc      = r_redirect_pc;
   assign bus.stat_branches    = r_stat_branches;
   assign bus.stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized bench for branch_predict_unit against a table-level reference model.
module tb_branch_predict_unit;

   logic clk;
   logic rst;

   bp_if #(.XLEN(32)) bus ();

   branch_predict_unit #(.INDEX_W(4), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_mis;

   // Reference model: strength 0 = strong not-taken .. 3 = strong taken.
   bit          m_valid [16];
   int unsigned m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_str   [16];
   logic [31:0] m_br;
   logic [31:0] m_mp;
   bit          m_flush;
   logic [31:0] m_redirect;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_str[i]   = 0;
      end
      m_br = 0; m_mp = 0; m_flush = 1'b0; m_redirect = 0;
   endtask

   task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
      int idx;
      bit hit;
      idx = int'((pc >> 2) & 32'hF);
      hit = m_valid[idx] && (m_tag[idx] == (pc >> 6));
      tk  = hit && (m_str[idx] >= 2);
      tg  = hit ? m_tgt[idx] : pc + 32'd4;
   endtask

   task automatic model_resolve(input logic v, br, tk, ptk, input logic [31:0] epc, etgt, eptgt);
      int idx;
      bit hit;
      bit misp;
      logic [31:0] actual;
      idx    = int'((epc >> 2) & 32'hF);
      hit    = m_valid[idx] && (m_tag[idx] == (epc >> 6));
      misp   = 1'b0;
      actual = epc + 32'd4;
      if (v && br) begin
         if (tk) actual = etgt;
         misp = (eptgt != actual) || (ptk != tk);
         if (hit) begin
            m_str[idx] = tk ? ((m_str[idx] < 3) ? m_str[idx] + 1 : 3)
                            : ((m_str[idx] > 0) ? m_str[idx] - 1 : 0);
            if (tk) m_tgt[idx] = etgt;
         end else if (tk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = epc >> 6;
            m_tgt[idx]   = etgt;
            m_str[idx]   = 2;
         end
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      end else if (v && ptk) begin
         misp = 1'b1;
         if (hit) m_valid[idx] = 1'b0;
      end
      if (misp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      m_flush = misp;
      if (misp) m_redirect = actual;
   endtask

   // One cycle: drive at negedge, check lookup before the edge, check registered state after.
   task automatic step(input logic v, br, tk, ptk, input logic [31:0] epc, etgt, eptgt, ifpc);
      logic        e_tk;
      logic [31:0] e_tg;
      bus.ex_valid       = v;
      bus.ex_is_branch   = br;
      bus.ex_taken       = tk;
      bus.ex_pred_taken  = ptk;
      bus.ex_pc          = epc;
      bus.ex_target      = etgt;
      bus.ex_pred_target = eptgt;
      bus.if_pc          = ifpc;
      #1;
      model_lookup(ifpc, e_tk, e_tg);
      chk("predict_taken", {31'd0, bus.predict_taken}, {31'd0, e_tk});
      chk("predict_target", bus.predict_target, e_tg);
      model_resolve(v, br, tk, ptk, epc, etgt, eptgt);
      @(posedge clk);
      #1;
      chk("flush", {31'd0, bus.flush}, {31'd0, m_flush});
      if (m_flush) chk("redirect_pc", bus.redirect_pc, m_redirect);
      chk("stat_branches", bus.stat_branches, m_br);
      chk("stat_mispredicts", bus.stat_mispredicts, m_mp);
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] ifpc);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ifpc);
   endtask

   initial begin
      logic        p_tk;
      logic [31:0] p_tg;
      logic        r_v, r_br, r_tk, r_ptk;
      logic [31:0] r_pc, r_tgt, r_ptgt;

      n_cmp = 0;
      n_mis = 0;
      model_reset();
      rst = 1'b1;
      bus.if_pc = 32'h100; bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_taken = 1'b0;
      bus.ex_pred_taken = 1'b0; bus.ex_pc = 0; bus.ex_target = 0; bus.ex_pred_target = 0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_flush", {31'd0, bus.flush}, 32'd0);
      chk("rst_redirect", bus.redirect_pc, 32'd0);
      chk("rst_stat_br", bus.stat_branches, 32'd0);
      chk("rst_stat_mp", bus.stat_mispredicts, 32'd0);
      chk("rst_pred_taken", {31'd0, bus.predict_taken}, 32'd0);
      chk("rst_pred_target", bus.predict_target, 32'h104);
      @(negedge clk);
      rst = 1'b0;

      // Allocate 0x100 with a taken-but-predicted-not-taken branch.
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 32'h104, 32'h100);
      idle(32'h100);
      // Not taken twice: 01 -> 11 -> 10; lookup in the same cycle still sees taken.
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 32'h80, 32'h100);
      idle(32'h100);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 32'h104, 32'h100);
      idle(32'h100);
      // Bring it back to taken, then alias from 0x140 (same index, other tag).
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 32'h104, 32'h100);
      idle(32'h100);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 32'h104, 32'h100);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h140, 32'h0, 32'h80, 32'h100);
      idle(32'h100);
      // Alias from the owning PC invalidates the entry.
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h80, 32'h100);
      idle(32'h100);

      // Randomized traffic over a few tags per index.
      for (int n = 0; n < 400; n++) begin
         r_pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         r_tgt = $urandom_range(0, 255) << 2;
         r_v   = m_flush ? 1'b0 : ($urandom_range(0, 9) != 0);
         r_br  = ($urandom_range(0, 4) != 0);
         r_tk  = $urandom_range(0, 1);
         model_lookup(r_pc, p_tk, p_tg);
         r_ptk  = p_tk;
         r_ptgt = p_tg;
         if ($urandom_range(0, 3) == 0) r_ptk = ~r_ptk;
         if ($urandom_range(0, 5) == 0) r_ptgt = $urandom_range(0, 255) << 2;
         step(r_v, r_br, r_tk, r_ptk, r_pc, r_tgt, r_ptgt,
              ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      end
      idle(32'h0);

      // Saturation of the mispredict counter via backdoor.
      force dut.r_stat_mispredicts = 32'hFFFF_FFFE;
      #1;
      release dut.r_stat_mispredicts;
      m_mp = 32'hFFFF_FFFE;
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h10, 32'h300);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h304, 32'h0, 32'h10, 32'h300);

      // Reset while flush is high.
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 32'h104, 32'h100);
      #1;
      chk("pre_rst_flush", {31'd0, bus.flush}, 32'd1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_flush", {31'd0, bus.flush}, 32'd0);
      chk("mid_rst_redirect", bus.redirect_pc, 32'd0);
      chk("mid_rst_stat_mp", bus.stat_mispredicts, 32'd0);
      bus.if_pc = 32'h100;
      #1;
      chk("mid_rst_pred_taken", {31'd0, bus.predict_taken}, 32'd0);
      chk("mid_rst_pred_target", bus.predict_target, 32'h104);
      @(negedge clk);
      rst = 1'b0;
      idle(32'h100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Branch prediction controller for the pipelined core. It owns a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB), answers fetch-stage lookups combinationally, and applies execute-stage resolutions on the clock edge. It detects mispredictions and issues a registered one-cycle flush with a redirect PC to the fetch and decode stages. It also keeps saturating branch and mispredict statistics.

## Interface
- INDEX_W, 4, table index width; table has 2^INDEX_W entries, indexed by pc[INDEX_W+1:2]
- XLEN, 32, PC and target width
- clk  in  1  clock; rising edge active
- rst  in  1  asynchronous, active-high reset
- if_pc  in  XLEN  fetch PC for lookup
- predict_taken  out  1  lookup result: BTB hit and counter in a taken state
- predict_target  out  XLEN  BTB target on hit; if_pc+4 otherwise
- ex_valid  in  1  execute-stage instruction is valid and not squashed
- ex_is_branch  in  1  execute instruction is a conditional branch or jump
- ex_pc  in  XLEN  execute instruction PC
- ex_taken  in  1  resolved direction
- ex_target  in  XLEN  resolved taken target
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pred_target  in  XLEN  predicted next PC carried down the pipe
- flush  out  1  registered; squash IF/ID and load redirect_pc
- redirect_pc  out  XLEN  correct next PC, valid while flush=1
- stat_branches  out  32  count of resolved branches, saturating
- stat_mispredicts  out  32  count of mispredicts, saturating

## Operation
- Counter encoding: STRONG_TAKEN=00, WEAK_TAKEN=01, WEAK_NOT_TAKEN=11, STRONG_NOT_TAKEN=10.
- Counter transitions:
  - taken: 10→11→01→00→00.
  - not taken: 00→01→11→10→10.
- Entry fields: valid, tag = pc[XLEN-1:INDEX_W+2], target, and a 2-bit counter.
- Lookup (combinational):
  - hit = valid[idx] & (tag[idx] == if_pc tag).
  - predict_taken = hit & counter[idx] in {00,01}.
- Resolution, when ex_valid & ex_is_branch:
  - actual = ex_taken ? ex_target : ex_pc+4.
  - mispredict = (ex_pred_target != actual) | (ex_pred_taken != ex_taken).
- Table update for a branch with an update-side hit:
  - Counter advances by ex_taken.
  - If taken, the target is overwritten with ex_target.
- Table update for a branch with an update-side miss:
  - If taken, allocate: valid=1, tag and target written, counter set to WEAK_TAKEN.
  - If not taken, no change.
- Alias case (ex_valid & ~ex_is_branch & ex_pred_taken):
  - Treated as a mispredict; actual = ex_pc+4.
  - The indexed entry is invalidated if its tag matches.
  - Not counted in stat_branches; counted in stat_mispredicts.
- Redirect: on any mispredict, flush=1 and redirect_pc=actual are registered for the next cycle only.
- Statistics:
  - stat_branches increments per resolved branch.
  - stat_mispredicts increments per mispredict.
  - Both hold at 32'hFFFF_FFFF once reached.
- Reset values:
  - All valid bits 0 and all counters STRONG_NOT_TAKEN.
  - flush=0, redirect_pc=0, both statistics counters 0.
  - Tags and targets need no reset.

## Timing
- Lookup is zero-latency combinational from if_pc and the current table state.
- Updates commit at the rising edge after ex_valid is sampled.
- Flush is asserted exactly one cycle after the mispredicting instruction is in EX, and lasts one cycle.
- Same-cycle lookup and update to the same index: the lookup sees pre-update state. There is no bypass.
- Back-to-back mispredicts produce back-to-back flush cycles, each with its own redirect_pc.
- While flush=1, ex_valid must arrive as 0 from the pipeline. The block does not filter it.
- rst asserted mid-operation clears flush immediately (asynchronously) along with all reset-state fields.

## Structure
- Shared package bp_pkg holds:
  - the four counter-encoding constants;
  - the default INDEX_W;
  - the counter next-state function bp_next_state(state, taken).
- One sub-module, bp_counter_next, is a combinational 2-bit next-state plus taken decode. It is instantiated once on the update path.
- The statistics counters are inline; no separate module.

## Test plan
- Reset, then lookup if_pc=0x100 → predict_taken=0, predict_target=0x104, flush=0, stats=0.
- Taken branch at ex_pc=0x100 with ex_target=0x80 and ex_pred_taken=0:
  - Next cycle: flush=1, redirect_pc=0x80.
  - Lookup 0x100 now gives predict_taken=1, target 0x80.
  - stat_mispredicts=1.
- Same branch resolved not taken twice after allocation:
  - Counter goes 01→11→10.
  - Lookup gives predict_taken=0 after the first resolution.
- Tag alias: the entry for 0x100 is allocated, then a non-branch at 0x140 (INDEX_W=4) arrives with ex_pred_taken=1:
  - flush=1, redirect_pc=0x144.
  - The 0x100 entry stays valid (tag mismatch).
- Same-cycle lookup and update at the same index: predict_taken reflects the old counter; the next-cycle lookup reflects the new one.
- Force stat_mispredicts to 0xFFFF_FFFF via a backdoor, then cause a mispredict → the count stays at 0xFFFF_FFFF.
- Assert rst while flush=1 → flush drops immediately and the table lookup misses.
